// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: opcodes, branch codes, states, classes.
package mc_ctrl_pkg;

  localparam logic [5:0] R_TYPE  = 6'h00;
  localparam logic [5:0] ALUI_LO = 6'h01;
  localparam logic [5:0] ALUI_HI = 6'h0F;
  localparam logic [5:0] LUI     = 6'h10;
  localparam logic [5:0] LD      = 6'h11;
  localparam logic [5:0] ST      = 6'h12;
  localparam logic [5:0] MOVE    = 6'h14;
  localparam logic [5:0] CMOV    = 6'h15;
  localparam logic [5:0] BR      = 6'h20;
  localparam logic [5:0] BMI     = 6'h21;
  localparam logic [5:0] BPL     = 6'h22;
  localparam logic [5:0] BZ      = 6'h23;
  localparam logic [5:0] HALT    = 6'h24;
  localparam logic [5:0] NOP     = 6'h25;
  localparam logic [5:0] CALL    = 6'h26;

  localparam logic [2:0] BROP_BR   = 3'b000;
  localparam logic [2:0] BROP_BMI  = 3'b001;
  localparam logic [2:0] BROP_BPL  = 3'b010;
  localparam logic [2:0] BROP_BZ   = 3'b011;
  localparam logic [2:0] BROP_NONE = 3'b100;

  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC   = 4'd3;
  localparam logic [3:0] S_EXEC2  = 4'd4;
  localparam logic [3:0] S_MEM    = 4'd5;
  localparam logic [3:0] S_WB     = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_HALTED = 4'd8;
  localparam logic [3:0] S_INTR   = 4'd9;

  typedef enum logic [3:0] {
    CLS_ALUR,
    CLS_ALUI,
    CLS_LUI,
    CLS_MOVE,
    CLS_CMOV,
    CLS_LD,
    CLS_ST,
    CLS_BR,
    CLS_CALL,
    CLS_NOP,
    CLS_HALT,
    CLS_ILL
  } cls_e;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decode: IR fields to instruction class and static datapath selects.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPW   = 6,
  parameter int unsigned FUNCW = 5,
  parameter int unsigned ALUW  = 4
) (
  input  logic [OPW-1:0]   opcode,
  input  logic [FUNCW-1:0] func,
  output cls_e             cls,
  output logic [ALUW-1:0]  alu_op,
  output logic [2:0]       br_op,
  output logic             alu_src,
  output logic             reg_alu_out,
  output logic             imm_sel,
  output logic             is_cmov,
  output logic             link
);

  logic [5:0] op6;
  logic       hi_bits;
  logic       unused_func;

  assign op6         = opcode[5:0];
  // Any set bit above the 6-bit opcode space makes the encoding illegal.
  assign hi_bits     = |(opcode >> 6);
  assign unused_func = ^(func >> ALUW);

  always_comb begin
    cls         = CLS_ILL;
    alu_op      = '0;
    br_op       = BROP_NONE;
    alu_src     = 1'b0;
    reg_alu_out = 1'b0;
    imm_sel     = 1'b0;
    is_cmov     = 1'b0;
    link        = 1'b0;
    if (!hi_bits) begin
      if (op6 == R_TYPE) begin
        cls         = CLS_ALUR;
        alu_op      = func[ALUW-1:0] - ALUW'(1);
        alu_src     = 1'b1;
        reg_alu_out = 1'b1;
      end else if (op6 >= ALUI_LO && op6 <= ALUI_HI) begin
        cls    = CLS_ALUI;
        alu_op = opcode[ALUW-1:0] - ALUW'(1);
      end else begin
        case (op6)
          LUI: begin
            cls    = CLS_LUI;
            alu_op = '1;
          end
          LD: cls = CLS_LD;
          ST: cls = CLS_ST;
          MOVE: begin
            cls         = CLS_MOVE;
            alu_src     = 1'b1;
            reg_alu_out = 1'b1;
          end
          CMOV: begin
            cls     = CLS_CMOV;
            is_cmov = 1'b1;
          end
          BR, BMI, BPL, BZ: begin
            cls     = CLS_BR;
            imm_sel = 1'b1;
            br_op   = op6[2:0];
          end
          CALL: begin
            cls     = CLS_CALL;
            br_op   = BROP_BR;
            imm_sel = 1'b1;
            link    = 1'b1;
          end
          HALT:    cls = CLS_HALT;
          NOP:     cls = CLS_NOP;
          default: cls = CLS_ILL;
        endcase
      end
    end
  end

endmodule

// File: rtl/mc_ctrl_seq.sv
// Multicycle control sequencer: steps a latched instruction through its phases and drives
// registered datapath selects and strobes, with memory timeout and boundary interrupts.
module mc_ctrl_seq
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPW     = 6,
  parameter int unsigned FUNCW   = 5,
  parameter int unsigned ALUW    = 4,
  parameter int unsigned MEM_TMO = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   opcode,
  input  logic [FUNCW-1:0] func,
  input  logic             int_req,
  input  logic             mem_rdy,
  output logic [ALUW-1:0]  alu_op,
  output logic [2:0]       br_op,
  output logic             alu_src,
  output logic             reg_alu_out,
  output logic             imm_sel,
  output logic             m_to_reg,
  output logic             is_cmov,
  output logic             link,
  output logic             rd_mem,
  output logic             wr_mem,
  output logic             wr_reg,
  output logic             upd_pc,
  output logic             int_ack,
  output logic             busy,
  output logic             illegal
);

  localparam int unsigned   TW       = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TMO - 1);

  logic [3:0]       state_q, state_d;
  logic [OPW-1:0]   ir_op_q, ir_op_d;
  logic [FUNCW-1:0] ir_fn_q, ir_fn_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             int_pend_q, int_pend_d;
  logic             illegal_q, illegal_d;
  logic             wake_q, wake_d;

  cls_e             cls;
  logic [ALUW-1:0]  dec_alu_op;
  logic [2:0]       dec_br_op;
  logic             dec_alu_src, dec_reg_alu_out, dec_imm_sel, dec_is_cmov, dec_link;

  logic [ALUW-1:0]  alu_op_d;
  logic [2:0]       br_op_d;
  logic             alu_src_d, reg_alu_out_d, imm_sel_d, m_to_reg_d, is_cmov_d, link_d;
  logic             rd_mem_d, wr_mem_d, wr_reg_d, upd_pc_d, int_ack_d, busy_d;
  logic             in_body;

  // Decoding the next IR lets the output registers see the class in the same edge as FETCH.
  mc_ctrl_decode #(
    .OPW  (OPW),
    .FUNCW(FUNCW),
    .ALUW (ALUW)
  ) u_decode (
    .opcode     (ir_op_d),
    .func       (ir_fn_d),
    .cls        (cls),
    .alu_op     (dec_alu_op),
    .br_op      (dec_br_op),
    .alu_src    (dec_alu_src),
    .reg_alu_out(dec_reg_alu_out),
    .imm_sel    (dec_imm_sel),
    .is_cmov    (dec_is_cmov),
    .link       (dec_link)
  );

  always_comb begin
    state_d    = state_q;
    ir_op_d    = ir_op_q;
    ir_fn_d    = ir_fn_q;
    tmo_d      = tmo_q;
    wake_d     = wake_q;
    illegal_d  = illegal_q;
    int_pend_d = (state_q == S_INTR) ? 1'b0 : (int_pend_q | int_req);
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        ir_op_d = opcode;
        ir_fn_d = func;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          CLS_NOP:  state_d = S_DONE;
          CLS_HALT: state_d = S_HALTED;
          CLS_ILL: begin
            state_d   = S_DONE;
            illegal_d = 1'b1;
          end
          default:  state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          CLS_CMOV: state_d = S_EXEC2;
          CLS_BR:   state_d = S_DONE;
          CLS_LD, CLS_ST: begin
            state_d = S_MEM;
            tmo_d   = '0;
          end
          default:  state_d = S_WB;
        endcase
      end
      S_EXEC2: state_d = S_WB;
      S_MEM: begin
        if (mem_rdy) begin
          state_d = (cls == CLS_LD) ? S_WB : S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = S_DONE;
          illegal_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WB:   state_d = S_DONE;
      S_DONE: state_d = int_pend_q ? S_INTR : S_FETCH;
      S_HALTED: begin
        if (int_pend_q) begin
          state_d = S_INTR;
          wake_d  = 1'b1;
        end
      end
      S_INTR: begin
        // Waking from HALTED still owes the PC update of the HALT instruction.
        state_d = wake_q ? S_DONE : S_FETCH;
        wake_d  = 1'b0;
      end
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    in_body       = state_d inside {S_DECODE, S_EXEC, S_EXEC2, S_MEM, S_WB};
    alu_op_d      = in_body ? dec_alu_op : '0;
    br_op_d       = in_body ? dec_br_op : BROP_NONE;
    alu_src_d     = in_body & dec_alu_src;
    reg_alu_out_d = in_body & dec_reg_alu_out;
    imm_sel_d     = in_body & dec_imm_sel;
    is_cmov_d     = in_body & dec_is_cmov;
    link_d        = in_body & dec_link;
    m_to_reg_d    = (state_d == S_WB) && (cls == CLS_LD);
    rd_mem_d      = (state_d == S_MEM) && (cls == CLS_LD);
    wr_mem_d      = (state_d == S_MEM) && (cls == CLS_ST);
    wr_reg_d      = (state_d == S_WB);
    upd_pc_d      = (state_d == S_DONE);
    int_ack_d     = (state_d == S_INTR);
    busy_d        = (state_d != S_RST) && (state_d != S_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RST;
      ir_op_q     <= '0;
      ir_fn_q     <= '0;
      tmo_q       <= '0;
      int_pend_q  <= 1'b0;
      illegal_q   <= 1'b0;
      wake_q      <= 1'b0;
      alu_op      <= '0;
      br_op       <= BROP_NONE;
      alu_src     <= 1'b0;
      reg_alu_out <= 1'b0;
      imm_sel     <= 1'b0;
      m_to_reg    <= 1'b0;
      is_cmov     <= 1'b0;
      link        <= 1'b0;
      rd_mem      <= 1'b0;
      wr_mem      <= 1'b0;
      wr_reg      <= 1'b0;
      upd_pc      <= 1'b0;
      int_ack     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_op_q     <= ir_op_d;
      ir_fn_q     <= ir_fn_d;
      tmo_q       <= tmo_d;
      int_pend_q  <= int_pend_d;
      illegal_q   <= illegal_d;
      wake_q      <= wake_d;
      alu_op      <= alu_op_d;
      br_op       <= br_op_d;
      alu_src     <= alu_src_d;
      reg_alu_out <= reg_alu_out_d;
      imm_sel     <= imm_sel_d;
      m_to_reg    <= m_to_reg_d;
      is_cmov     <= is_cmov_d;
      link        <= link_d;
      rd_mem      <= rd_mem_d;
      wr_mem      <= wr_mem_d;
      wr_reg      <= wr_reg_d;
      upd_pc      <= upd_pc_d;
      int_ack     <= int_ack_d;
      busy        <= busy_d;
    end
  end

  assign illegal = illegal_q;

endmodule
